el2_exu_alu_result_collector: RTL and testbench

Reassembles the serialized ALU result packet at NoC node `POS_ALU_RCV`. The ALU wrapper's serial sender emits this packet as a stream of flits. This block sits directly downstream of that sender on the EXU NoC. It accepts flits with a valid/ready handshake, validates head/tail framing and flit count, and rebuilds the parallel packet. Completed packets are buffered in a 2-entry FIFO, which the EXU writeback/flush logic drains with its own valid/ready handshake.

---
 rtl/el2_exu_alu_result_collector.sv | 156 +++++++++++++++
 tb/tb_el2_exu_alu_result_collector.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/el2_exu_alu_result_collector.sv
// Rebuilds serialized ALU result packets from NoC flits and queues them in a 2-entry FWFT FIFO.
// Define ALU_RCV_ERRCNT_EN to get a saturating framing-error counter on err_count.
module el2_exu_alu_result_collector #(
    parameter int unsigned PACKET_BITS    = 128,
    parameter int unsigned FLIT_DATA_BITS = 32,
    parameter int unsigned NUM_FLITS      = PACKET_BITS / FLIT_DATA_BITS
) (
    input  logic                      clk,
    input  logic                      rst_l,
    input  logic                      flush,
    input  logic                      flit_valid,
    input  logic                      flit_head,
    input  logic                      flit_tail,
    input  logic [FLIT_DATA_BITS-1:0] flit_data,
    output logic                      flit_ready,
    output logic                      pkt_valid,
    output logic [PACKET_BITS-1:0]    pkt_data,
    input  logic                      pkt_ready,
    output logic [7:0]                err_count
);

    localparam int unsigned IdxW = $clog2(NUM_FLITS);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_FLITS - 1);

    typedef enum logic [0:0] {StIdle, StCollect} state_e;

    state_e                 state_q, state_d;
    logic [IdxW-1:0]        idx_q, idx_d;
    logic [PACKET_BITS-1:0] asm_q, asm_d;
    logic [PACKET_BITS-1:0] mem_q [2];
    logic                   wr_ptr_q, rd_ptr_q;
    logic [1:0]             count_q;
    logic                   fire, push, pop;

    assign flit_ready = (count_q != 2'd2);
    assign pkt_valid  = (count_q != 2'd0);
    assign pkt_data   = mem_q[rd_ptr_q];
    assign fire       = flit_valid && flit_ready && !flush;
    assign pop        = pkt_valid && pkt_ready && !flush;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        asm_d   = asm_q;
        push    = 1'b0;
        if (flush) begin
            state_d = StIdle;
            idx_d   = '0;
        end else if (fire) begin
            unique case (state_q)
                StIdle: begin
                    if (flit_head && !flit_tail) begin
                        asm_d[FLIT_DATA_BITS-1:0] = flit_data;
                        idx_d   = IdxW'(1);
                        state_d = StCollect;
                    end
                end
                StCollect: begin
                    if (flit_head) begin
                        // Partial packet is abandoned; a bare head restarts assembly.
                        if (!flit_tail) begin
                            asm_d[FLIT_DATA_BITS-1:0] = flit_data;
                            idx_d = IdxW'(1);
                        end else begin
                            state_d = StIdle;
                            idx_d   = '0;
                        end
                    end else if (flit_tail) begin
                        if (idx_q == LastIdx) begin
                            asm_d[int'(idx_q)*FLIT_DATA_BITS +: FLIT_DATA_BITS] = flit_data;
                            push = 1'b1;
                        end
                        state_d = StIdle;
                        idx_d   = '0;
                    end else if (idx_q != LastIdx) begin
                        asm_d[int'(idx_q)*FLIT_DATA_BITS +: FLIT_DATA_BITS] = flit_data;
                        idx_d = idx_q + IdxW'(1);
                    end else begin
                        state_d = StIdle;
                        idx_d   = '0;
                    end
                end
                default: begin
                    state_d = StIdle;
                    idx_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q <= StIdle;
            idx_q   <= '0;
            asm_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            asm_q   <= asm_d;
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            for (int i = 0; i < 2; i++) mem_q[i] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else if (flush) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= asm_d;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            if (push && !pop)      count_q <= count_q + 2'd1;
            else if (!push && pop) count_q <= count_q - 2'd1;
        end
    end

`ifdef ALU_RCV_ERRCNT_EN
    logic       err_event;
    logic [7:0] err_q;

    always_comb begin
        err_event = 1'b0;
        if (fire) begin
            if (state_q == StIdle) begin
                err_event = !flit_head || flit_tail;
            end else if (flit_head) begin
                err_event = 1'b1;
            end else if (flit_tail) begin
                err_event = (idx_q != LastIdx);
            end else begin
                err_event = (idx_q == LastIdx);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            err_q <= 8'd0;
        end else if (err_event && err_q != 8'hff) begin
            err_q <= err_q + 8'd1;
        end
    end

    assign err_count = err_q;
`else
    assign err_count = 8'd0;
`endif

endmodule

// File: tb/tb_el2_exu_alu_result_collector.sv
// Scoreboard bench for el2_exu_alu_result_collector: directed flit streams, queued expectations.
module tb_el2_exu_alu_result_collector;

    logic         clk = 1'b0;
    logic         rst_l;
    logic         flush;
    logic         flit_valid;
    logic         flit_head;
    logic         flit_tail;
    logic [31:0]  flit_data;
    logic         flit_ready;
    logic         pkt_valid;
    logic [127:0] pkt_data;
    logic         pkt_ready;
    logic [7:0]   err_count;

`ifdef ALU_RCV_ERRCNT_EN
    localparam bit ErrEn = 1'b1;
`else
    localparam bit ErrEn = 1'b0;
`endif

    int           checks = 0;
    int           errors = 0;
    int           exp_err = 0;
    logic [127:0] exp_q [$];

    always #5 clk = ~clk;

    el2_exu_alu_result_collector dut (
        .clk        (clk),
        .rst_l      (rst_l),
        .flush      (flush),
        .flit_valid (flit_valid),
        .flit_head  (flit_head),
        .flit_tail  (flit_tail),
        .flit_data  (flit_data),
        .flit_ready (flit_ready),
        .pkt_valid  (pkt_valid),
        .pkt_data   (pkt_data),
        .pkt_ready  (pkt_ready),
        .err_count  (err_count)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every packet handed to the consumer must match the scoreboard head.
    always @(negedge clk) begin
        if (rst_l && !flush && pkt_valid && pkt_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pkt: got %h expected none", pkt_data);
            end else begin
                check("pkt_data", pkt_data, exp_q.pop_front());
            end
        end
    end

    task automatic send_flit(input logic h, input logic t, input logic [31:0] d);
        logic acc;
        int   waited = 0;
        flit_valid = 1'b1;
        flit_head  = h;
        flit_tail  = t;
        flit_data  = d;
        forever begin
            @(negedge clk);
            acc = flit_ready;
            @(posedge clk);
            #1;
            if (acc) break;
            waited++;
            if (waited > 200) begin
                checks++;
                errors++;
                $display("FAIL flit_accept_timeout: got ready=0 expected ready=1");
                break;
            end
        end
        flit_valid = 1'b0;
        flit_head  = 1'b0;
        flit_tail  = 1'b0;
    endtask

    task automatic send_pkt(input logic [31:0] base);
        send_flit(1'b1, 1'b0, base);
        send_flit(1'b0, 1'b0, base + 32'h1);
        send_flit(1'b0, 1'b0, base + 32'h2);
        send_flit(1'b0, 1'b1, base + 32'h3);
    endtask

    function automatic logic [127:0] pkt_of(input logic [31:0] base);
        return {base + 32'h3, base + 32'h2, base + 32'h1, base};
    endfunction

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain_remaining", 128'(exp_q.size()), 128'd0);
    endtask

    initial begin
        rst_l      = 1'b0;
        flush      = 1'b0;
        flit_valid = 1'b0;
        flit_head  = 1'b0;
        flit_tail  = 1'b0;
        flit_data  = '0;
        pkt_ready  = 1'b1;
        #12 rst_l = 1'b1;
        @(posedge clk);
        #1;
        check("rst_flit_ready", 128'(flit_ready), 128'd1);
        check("rst_pkt_valid", 128'(pkt_valid), 128'd0);
        check("rst_pkt_data", pkt_data, 128'd0);
        check("rst_err_count", 128'(err_count), 128'd0);

        // Legal packet, latency one cycle after tail.
        exp_q.push_back(128'h44444444_33333333_22222222_11111111);
        send_flit(1'b1, 1'b0, 32'h11111111);
        send_flit(1'b0, 1'b0, 32'h22222222);
        send_flit(1'b0, 1'b0, 32'h33333333);
        send_flit(1'b0, 1'b1, 32'h44444444);
        check("tail_latency_valid", 128'(pkt_valid), 128'd1);
        wait_drain();

        // Backpressure: two packets fill the FIFO, third head stalls.
        pkt_ready = 1'b0;
        exp_q.push_back(pkt_of(32'hA0000000));
        exp_q.push_back(pkt_of(32'hB0000000));
        exp_q.push_back(pkt_of(32'hC0000000));
        send_pkt(32'hA0000000);
        check("one_entry_ready", 128'(flit_ready), 128'd1);
        send_pkt(32'hB0000000);
        check("full_ready_low", 128'(flit_ready), 128'd0);
        fork
            send_pkt(32'hC0000000);
            begin
                repeat (4) @(posedge clk);
                #1;
                check("stall_ready_low", 128'(flit_ready), 128'd0);
                check("stall_head_pkt", pkt_data, pkt_of(32'hA0000000));
                pkt_ready = 1'b1;
            end
        join
        wait_drain();

        // Framing errors: short packet, orphan tail, head+tail.
        send_flit(1'b1, 1'b0, 32'h5);
        send_flit(1'b0, 1'b0, 32'h6);
        send_flit(1'b0, 1'b1, 32'h7);
        if (ErrEn) exp_err++;
        send_flit(1'b0, 1'b1, 32'h8);
        if (ErrEn) exp_err++;
        send_flit(1'b1, 1'b1, 32'h9);
        if (ErrEn) exp_err++;
        check("framing_pkt_valid", 128'(pkt_valid), 128'd0);
        check("framing_err_count", 128'(err_count), 128'(exp_err));
        exp_q.push_back(pkt_of(32'hD0000000));
        send_pkt(32'hD0000000);
        wait_drain();
        check("after_framing_err", 128'(err_count), 128'(exp_err));

        // Re-head: partial packet A replaced by packet B.
        send_flit(1'b1, 1'b0, 32'hAAAA0000);
        send_flit(1'b0, 1'b0, 32'hAAAA0001);
        exp_q.push_back(pkt_of(32'hBBBB0000));
        send_pkt(32'hBBBB0000);
        if (ErrEn) exp_err++;
        wait_drain();
        check("rehead_err_count", 128'(err_count), 128'(exp_err));

        // Flush mid-packet with one packet held.
        pkt_ready = 1'b0;
        send_pkt(32'hE0000000);
        check("held_pkt_valid", 128'(pkt_valid), 128'd1);
        send_flit(1'b1, 1'b0, 32'hE1000000);
        flush      = 1'b1;
        flit_valid = 1'b1;
        flit_data  = 32'hE1000001;
        @(posedge clk);
        #1;
        flush      = 1'b0;
        flit_valid = 1'b0;
        check("flush_pkt_valid", 128'(pkt_valid), 128'd0);
        check("flush_flit_ready", 128'(flit_ready), 128'd1);
        pkt_ready = 1'b1;
        exp_q.push_back(pkt_of(32'hF0000000));
        send_pkt(32'hF0000000);
        wait_drain();
        check("flush_err_count", 128'(err_count), 128'(exp_err));

        // Async reset between edges with a packet held and another in flight.
        pkt_ready = 1'b0;
        send_pkt(32'h12340000);
        send_flit(1'b1, 1'b0, 32'h56780000);
        send_flit(1'b0, 1'b0, 32'h56780001);
        #2 rst_l = 1'b0;
        #1;
        check("arst_flit_ready", 128'(flit_ready), 128'd1);
        check("arst_pkt_valid", 128'(pkt_valid), 128'd0);
        check("arst_pkt_data", pkt_data, 128'd0);
        check("arst_err_count", 128'(err_count), 128'd0);
        exp_err = 0;
        #3 rst_l = 1'b1;
        pkt_ready = 1'b1;
        @(posedge clk);
        #1;
        exp_q.push_back(pkt_of(32'h9ABC0000));
        send_pkt(32'h9ABC0000);
        wait_drain();
        check("post_reset_err_count", 128'(err_count), 128'(exp_err));

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
